bfp_rescale_unit: RTL and testbench

Parametrised, streaming block-floating-point rescaler for FFT stage outputs: accepts LANES complex samples per beat, applies a per-frame arithmetic right shift with selectable rounding, and tracks the cumulative scale factor. In dynamic mode the shift applied to frame k+1 is derived from the exact peak magnitude of frame k. In static mode the shift comes from configuration. Sits between FFT butterfly stages and the stage memory, with valid/ready handshakes on both sides.

---
 rtl/fft_rescale_pkg.sv | 15 +
 rtl/bfp_round_shift.sv | 25 ++
 rtl/bfp_rescale_unit.sv | 123 ++++++++++++
 tb/tb_bfp_rescale_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_rescale_pkg.sv
// fft_rescale_pkg: shared types, defaults and helpers for the block-floating-point rescaler.
package fft_rescale_pkg;
  typedef enum logic [1:0] {
    RM_TRUNC     = 2'b00,
    RM_HALF_UP   = 2'b01,
    RM_CONV      = 2'b10,
    RM_TRUNC_ALT = 2'b11
  } round_mode_e;
  localparam int DATA_W_DEF = 16;
  localparam int LANES_DEF = 1;
  // Callers sign-extend into 64 bits, so the most negative sample maps to its exact magnitude.
  function automatic logic [63:0] magnitude(input logic signed [63:0] x);
    return x[63] ? 64'(-x) : 64'(x);
  endfunction
endpackage

// File: rtl/bfp_round_shift.sv
// bfp_round_shift: arithmetic right shift of one component with floor, half-up or half-even rounding.
module bfp_round_shift import fft_rescale_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int SH_W = 2
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [SH_W-1:0]   shift_i,
  input  round_mode_e       mode_i,
  output logic [DATA_W-1:0] data_o
);
  localparam int W = DATA_W + 1;
  logic signed [W-1:0] xw, fl;
  logic [W-1:0] mask, rem, half;
  logic up;
  assign xw = {data_i[DATA_W-1], data_i};
  assign fl = xw >>> shift_i;
  assign mask = (W'(1) << shift_i) - W'(1);
  assign rem = xw & mask;
  // half is zero for a zero shift, which the shift_i guard below relies on
  assign half = mask - (mask >> 1);
  assign up = (shift_i != '0) &&
              (mode_i == RM_HALF_UP ? rem >= half :
               mode_i == RM_CONV && (rem > half || (rem == half && fl[0])));
  assign data_o = DATA_W'(fl + W'(up));
endmodule

// File: rtl/bfp_rescale_unit.sv
// bfp_rescale_unit: streaming block-floating-point rescaler with per-frame shift and scale tracking.
module bfp_rescale_unit import fft_rescale_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES = LANES_DEF,
  parameter int FRAME_LEN = 1024,
  parameter int MAX_SHIFT = 2,
  parameter int SCALE_W = 8,
  localparam int SH_W = $clog2(MAX_SHIFT + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [LANES*DATA_W-1:0] data_real_i,
  input  logic [LANES*DATA_W-1:0] data_imag_i,
  input  logic                    data_valid_i,
  output logic                    data_ready_o,
  output logic [LANES*DATA_W-1:0] data_real_o,
  output logic [LANES*DATA_W-1:0] data_imag_o,
  output logic                    data_valid_o,
  output logic                    data_last_o,
  input  logic                    data_ready_i,
  input  logic                    rescale_mode_i,
  input  logic [1:0]              rounding_mode_i,
  input  logic [SH_W-1:0]         cfg_shift_i,
  input  logic [DATA_W-2:0]       rescale_threshold_i,
  input  logic                    scale_clear_i,
  output logic [SCALE_W-1:0]      scale_factor_o,
  output logic [SH_W-1:0]         frame_shift_o,
  output logic                    frame_done_o,
  output logic                    overflow_detected_o
);
  localparam int FRAME_BEATS = FRAME_LEN / LANES;
  localparam int CNT_W = FRAME_BEATS > 1 ? $clog2(FRAME_BEATS) : 1;
  localparam int PW = DATA_W + MAX_SHIFT;
  logic en, last_beat, s1_valid, s1_first, s1_last, beat_ovf;
  logic [CNT_W-1:0] beat_cnt;
  logic [LANES*DATA_W-1:0] s1_real, s1_imag, rs_real, rs_imag;
  logic [DATA_W-1:0] peak_reg, beat_peak, frame_peak;
  logic [DATA_W-1:0] mag_in [2*LANES];
  logic [DATA_W-1:0] mag_out [2*LANES];
  logic [SH_W-1:0] pending_shift, peak_shift, static_shift, shift_nxt;
  logic [SCALE_W:0] scale_sum;
  round_mode_e rmode;
  assign en = !data_valid_o || data_ready_i;
  assign data_ready_o = en;
  assign frame_done_o = data_valid_o && data_ready_i && data_last_o;
  assign last_beat = beat_cnt == CNT_W'(FRAME_BEATS - 1);
  assign rmode = round_mode_e'(rounding_mode_i);
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DATA_W-1:0] ir, ii, orr, oi;
    assign ir = s1_real[l*DATA_W +: DATA_W];
    assign ii = s1_imag[l*DATA_W +: DATA_W];
    assign mag_in[2*l] = DATA_W'(magnitude(64'(ir)));
    assign mag_in[2*l+1] = DATA_W'(magnitude(64'(ii)));
    bfp_round_shift #(.DATA_W(DATA_W), .SH_W(SH_W)) u_rs_real (
      .data_i(ir), .shift_i(shift_nxt), .mode_i(rmode), .data_o(orr));
    bfp_round_shift #(.DATA_W(DATA_W), .SH_W(SH_W)) u_rs_imag (
      .data_i(ii), .shift_i(shift_nxt), .mode_i(rmode), .data_o(oi));
    assign rs_real[l*DATA_W +: DATA_W] = orr;
    assign rs_imag[l*DATA_W +: DATA_W] = oi;
    assign mag_out[2*l] = DATA_W'(magnitude(64'(orr)));
    assign mag_out[2*l+1] = DATA_W'(magnitude(64'(oi)));
  end
  always_comb begin
    beat_peak = '0;
    beat_ovf = 1'b0;
    for (int j = 0; j < 2*LANES; j++) begin
      beat_peak = mag_in[j] > beat_peak ? mag_in[j] : beat_peak;
      beat_ovf = beat_ovf | (mag_out[j] >= {1'b0, rescale_threshold_i});
    end
    frame_peak = beat_peak > peak_reg ? beat_peak : peak_reg;
    peak_shift = '0;
    for (int k = 0; k < MAX_SHIFT; k++)
      peak_shift = PW'(frame_peak) >= (PW'(rescale_threshold_i) << k) ? peak_shift + SH_W'(1) : peak_shift;
    static_shift = cfg_shift_i > SH_W'(MAX_SHIFT) ? SH_W'(MAX_SHIFT) : cfg_shift_i;
    // a frame's first beat picks up its shift on the same edge it enters S2, so no bubble is needed
    shift_nxt = s1_first ? (rescale_mode_i ? static_shift : pending_shift) : frame_shift_o;
    scale_sum = {1'b0, scale_factor_o} + (SCALE_W+1)'(shift_nxt);
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      beat_cnt <= '0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last <= 1'b0;
      s1_real <= '0;
      s1_imag <= '0;
      peak_reg <= '0;
      pending_shift <= '0;
      frame_shift_o <= '0;
      scale_factor_o <= '0;
      overflow_detected_o <= 1'b0;
      data_valid_o <= 1'b0;
      data_last_o <= 1'b0;
      data_real_o <= '0;
      data_imag_o <= '0;
    end else begin
      if (data_valid_i && en) beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
      if (en) begin
        s1_valid <= data_valid_i;
        s1_real <= data_real_i;
        s1_imag <= data_imag_i;
        s1_first <= beat_cnt == '0;
        s1_last <= last_beat;
        data_valid_o <= s1_valid;
        data_last_o <= s1_valid && s1_last;
        if (s1_valid) begin
          data_real_o <= rs_real;
          data_imag_o <= rs_imag;
          frame_shift_o <= shift_nxt;
          peak_reg <= s1_last ? '0 : frame_peak;
          if (s1_last) pending_shift <= peak_shift;
          if (s1_first) scale_factor_o <= scale_sum[SCALE_W] ? '1 : scale_sum[SCALE_W-1:0];
          if (beat_ovf) overflow_detected_o <= 1'b1;
        end
      end
      if (scale_clear_i) begin
        scale_factor_o <= '0;
        overflow_detected_o <= 1'b0;
        pending_shift <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bfp_rescale_unit.sv
// tb_bfp_rescale_unit: scoreboard bench for bfp_rescale_unit with FRAME_LEN=4, LANES=1, thr=0x2000.
module tb_bfp_rescale_unit;
  logic clk = 1'b0;
  logic reset_n_i = 1'b0;
  logic [15:0] data_real_i = '0, data_imag_i = '0;
  logic data_valid_i = 1'b0, data_ready_i = 1'b1;
  logic rescale_mode_i = 1'b0, scale_clear_i = 1'b0;
  logic [1:0] rounding_mode_i = 2'b00, cfg_shift_i = 2'd0;
  logic [14:0] rescale_threshold_i = 15'h2000;
  logic data_ready_o, data_valid_o, data_last_o, frame_done_o, overflow_detected_o;
  logic [15:0] data_real_o, data_imag_o;
  logic [7:0] scale_factor_o;
  logic [1:0] frame_shift_o;
  typedef struct {
    logic [15:0] re, im;
    logic last;
    logic [1:0] sh;
    logic [7:0] sc;
    logic ovf;
    bit lat;
    int cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int n_tests = 0, n_fail = 0, n_push = 0, n_out = 0, cyc = 0;
  logic ovf_m = 1'b0;
  bfp_rescale_unit #(.DATA_W(16), .LANES(1), .FRAME_LEN(4), .MAX_SHIFT(2), .SCALE_W(8)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .data_real_i(data_real_i), .data_imag_i(data_imag_i), .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o), .data_real_o(data_real_o), .data_imag_o(data_imag_o),
    .data_valid_o(data_valid_o), .data_last_o(data_last_o), .data_ready_i(data_ready_i),
    .rescale_mode_i(rescale_mode_i), .rounding_mode_i(rounding_mode_i), .cfg_shift_i(cfg_shift_i),
    .rescale_threshold_i(rescale_threshold_i), .scale_clear_i(scale_clear_i),
    .scale_factor_o(scale_factor_o), .frame_shift_o(frame_shift_o),
    .frame_done_o(frame_done_o), .overflow_detected_o(overflow_detected_o));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask
  function automatic int absv(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    return s < 0 ? -s : s;
  endfunction
  task automatic send_beat(input logic [15:0] re, im, ere, eim, input logic last,
                           input logic [1:0] sh, input logic [7:0] sc, input bit lat);
    exp_t e;
    bit acc = 0;
    int n = 0, c = 0;
    data_real_i = re;
    data_imag_i = im;
    data_valid_i = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = data_ready_o;
      c = cyc;
      @(posedge clk);
      #1;
      scale_clear_i = 1'b0;
      n++;
    end
    if (!acc) check("accept timeout", 0, 1);
    if (absv(ere) >= 'h2000 || absv(eim) >= 'h2000) ovf_m = 1'b1;
    e.re = ere; e.im = eim; e.last = last; e.sh = sh; e.sc = sc;
    e.ovf = ovf_m; e.lat = lat; e.cyc = c;
    sb.push_back(e);
    n_push++;
    data_valid_i = 1'b0;
  endtask
  task automatic send_frame(input logic [3:0][15:0] re, im, ere, eim, input int sh, sc,
                            input bit lat, input bit clr);
    for (int b = 0; b < 4; b++) begin
      send_beat(re[3-b], im[3-b], ere[3-b], eim[3-b], b == 3, 2'(sh), 8'(sc), lat);
      if (b == 0 && clr) scale_clear_i = 1'b1;
    end
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset(input string tag);
    check({tag, " real"}, data_real_o, 0);
    check({tag, " imag"}, data_imag_o, 0);
    check({tag, " valid"}, data_valid_o, 0);
    check({tag, " last"}, data_last_o, 0);
    check({tag, " done"}, frame_done_o, 0);
    check({tag, " ovf"}, overflow_detected_o, 0);
    check({tag, " scale"}, scale_factor_o, 0);
    check({tag, " shift"}, frame_shift_o, 0);
    check({tag, " ready"}, data_ready_o, 1);
  endtask
  always @(negedge clk) begin
    if (reset_n_i && data_valid_o) begin
      if (sb.size() == 0) check("spurious output", 1, 0);
      else begin
        mon_e = sb[0];
        check("real", data_real_o, mon_e.re);
        check("imag", data_imag_o, mon_e.im);
        check("last", data_last_o, mon_e.last);
        check("done", frame_done_o, mon_e.last & data_ready_i);
        check("shift", frame_shift_o, mon_e.sh);
        check("scale", scale_factor_o, mon_e.sc);
        check("ovf", overflow_detected_o, mon_e.ovf);
        if (!data_ready_i) check("stall ready_o", data_ready_o, 0);
        else begin
          if (mon_e.lat) check("latency", cyc - mon_e.cyc, 2);
          void'(sb.pop_front());
          n_out++;
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk);
    #1;
    reset_n_i = 1'b1;
    send_frame({16'h1000, 16'h1000, 16'h1000, 16'h1000}, {16'hF000, 16'hF000, 16'hF000, 16'hF000},
               {16'h1000, 16'h1000, 16'h1000, 16'h1000}, {16'hF000, 16'hF000, 16'hF000, 16'hF000}, 0, 0, 1, 0);
    send_frame({16'h1000, 16'h1000, 16'h1000, 16'h1000}, {16'hF000, 16'hF000, 16'hF000, 16'hF000},
               {16'h1000, 16'h1000, 16'h1000, 16'h1000}, {16'hF000, 16'hF000, 16'hF000, 16'hF000}, 0, 0, 1, 0);
    send_frame({16'h3000, 16'h0100, 16'h0100, 16'h0100}, '0,
               {16'h3000, 16'h0100, 16'h0100, 16'h0100}, '0, 0, 0, 0, 0);
    send_frame({16'h3000, 16'h0100, 16'h0100, 16'h0100}, '0,
               {16'h1800, 16'h0080, 16'h0080, 16'h0080}, '0, 1, 1, 0, 0);
    drain();
    rounding_mode_i = 2'b01;
    send_frame({16'h8000, 16'h0004, 16'h0004, 16'h0004}, '0,
               {16'hC000, 16'h0002, 16'h0002, 16'h0002}, '0, 1, 2, 0, 0);
    send_frame({16'h8000, 16'h0003, 16'h0002, 16'h0006}, '0,
               {16'hE000, 16'h0001, 16'h0001, 16'h0002}, '0, 2, 4, 0, 0);
    drain();
    rounding_mode_i = 2'b00;
    send_frame({16'h8000, 16'h0003, 16'h0007, 16'hFFFD}, '0,
               {16'hE000, 16'h0000, 16'h0001, 16'hFFFF}, '0, 2, 6, 0, 0);
    drain();
    rounding_mode_i = 2'b10;
    send_frame({16'h0002, 16'h0006, 16'h000A, 16'h000E}, {16'hFFFA, 16'h0000, 16'h0000, 16'h0000},
               {16'h0000, 16'h0002, 16'h0002, 16'h0004}, {16'hFFFE, 16'h0000, 16'h0000, 16'h0000}, 2, 8, 0, 0);
    drain();
    rounding_mode_i = 2'b00;
    fork
      send_frame({16'h0100, 16'h0101, 16'h0102, 16'h0103}, '0,
                 {16'h0100, 16'h0101, 16'h0102, 16'h0103}, '0, 0, 8, 0, 0);
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        data_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        data_ready_i = 1'b1;
      end
    join
    drain();
    scale_clear_i = 1'b1;
    @(posedge clk);
    #1;
    scale_clear_i = 1'b0;
    ovf_m = 1'b0;
    @(negedge clk);
    check("clear scale", scale_factor_o, 0);
    check("clear ovf", overflow_detected_o, 0);
    @(posedge clk);
    #1;
    rescale_mode_i = 1'b1;
    cfg_shift_i = 2'd1;
    rounding_mode_i = 2'b01;
    send_frame({16'h7FFF, 16'h0100, 16'h0100, 16'h0100}, '0,
               {16'h4000, 16'h0080, 16'h0080, 16'h0080}, '0, 1, 1, 0, 0);
    cfg_shift_i = 2'd3;
    ovf_m = 1'b0;
    send_frame({16'h0100, 16'h7FFF, 16'h0004, 16'hFFFF}, '0,
               {16'h0040, 16'h2000, 16'h0001, 16'h0000}, '0, 2, 0, 0, 1);
    drain();
    rescale_mode_i = 1'b0;
    rounding_mode_i = 2'b00;
    send_beat(16'h3000, 16'h0000, 16'h0C00, 16'h0000, 1'b0, 2'd2, 8'd2, 0);
    send_beat(16'h3000, 16'h0000, 16'h0C00, 16'h0000, 1'b0, 2'd2, 8'd2, 0);
    data_real_i = 16'h3000;
    data_valid_i = 1'b1;
    reset_n_i = 1'b0;
    @(posedge clk);
    #1;
    n_push -= sb.size();
    sb.delete();
    ovf_m = 1'b0;
    data_valid_i = 1'b0;
    @(negedge clk);
    check_reset("mid-frame reset");
    @(posedge clk);
    #1;
    reset_n_i = 1'b1;
    send_frame({16'h3000, 16'h1000, 16'h1000, 16'h1000}, '0,
               {16'h3000, 16'h1000, 16'h1000, 16'h1000}, '0, 0, 0, 0, 0);
    send_frame({16'h2000, 16'h0800, 16'h0800, 16'h0800}, '0,
               {16'h1000, 16'h0400, 16'h0400, 16'h0400}, '0, 1, 1, 0, 0);
    drain();
    check("scoreboard empty", sb.size(), 0);
    check("beat count", n_out, n_push);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
